// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/sequencing controller for the 5-stage MIPS pipeline: stage enables, bubbles/flushes,
// registered EX forwarding selects and mem-wait timeout. Define HAZARD_STATS_EN for event counters.
module pipeline_hazard_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rt,
  input  logic             id_jump,
  input  logic             id_jr,
  input  logic [4:0]       ex_rd,
  input  logic             ex_regwrite,
  input  logic             ex_memread,
  input  logic [4:0]       mem_rd,
  input  logic             mem_regwrite,
  input  logic             mem_memread,
  input  logic             mem_branch_taken,
  input  logic             mem_busy,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic             id_ex_write,
  output logic             id_ex_bubble,
  output logic             ex_mem_write,
  output logic             ex_mem_bubble,
  output logic             mem_wb_write,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic             timeout_err
`ifdef HAZARD_STATS_EN
  ,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [CNT_W-1:0] wait_cnt
`endif
);

  typedef enum logic [1:0] {RUN, MEM_WAIT, FLUSH} state_t;

  state_t     state;
  logic [7:0] wait_ctr;
  logic       branch_go;
  logic       load_use;
  logic       jr_stall;
  logic       stall;
  logic       wait_hit;
  logic [1:0] fwd_a_next;
  logic [1:0] fwd_b_next;

  // Newest producer wins: EX result beats MEM result; $0 never forwards.
  function automatic logic [1:0] fwd_sel(input logic [4:0] r, input logic en);
    logic [1:0] sel;
    sel = 2'b00;
    if (en && r != '0) begin
      if (ex_regwrite && ex_rd == r)       sel = 2'b10;
      else if (mem_regwrite && mem_rd == r) sel = 2'b01;
    end
    return sel;
  endfunction

  always_comb begin
    // A branch seen in FLUSH belongs to an already squashed slot.
    branch_go  = mem_branch_taken && (state != FLUSH);
    load_use   = ex_memread && (ex_rd != '0) &&
                 ((ex_rd == id_rs) || (id_uses_rt && ex_rd == id_rt));
    jr_stall   = id_jr && (id_rs != '0) &&
                 ((ex_regwrite && ex_rd == id_rs) || (mem_memread && mem_rd == id_rs));
    stall      = load_use || jr_stall;
    wait_hit   = ({24'd0, wait_ctr} + 32'd1) >= MEM_TIMEOUT;
    fwd_a_next = fwd_sel(id_rs, 1'b1);
    fwd_b_next = fwd_sel(id_rt, id_uses_rt);
  end

  always_comb begin
    pc_write      = 1'b1;
    if_id_write   = 1'b1;
    if_id_flush   = 1'b0;
    id_ex_write   = 1'b1;
    id_ex_bubble  = 1'b0;
    ex_mem_write  = 1'b1;
    ex_mem_bubble = 1'b0;
    mem_wb_write  = 1'b1;
    // Leaving MEM_WAIT (busy low) decodes exactly like RUN in the same cycle.
    if (mem_busy) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_write  = 1'b0;
      ex_mem_write = 1'b0;
      mem_wb_write = 1'b0;
    end else if (branch_go) begin
      if_id_flush   = 1'b1;
      id_ex_bubble  = 1'b1;
      ex_mem_bubble = 1'b1;
    end else if (stall) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_bubble = 1'b1;
    end else if (id_jump || id_jr) begin
      if_id_flush = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= RUN;
      wait_ctr    <= '0;
      timeout_err <= 1'b0;
      fwd_a       <= '0;
      fwd_b       <= '0;
    end else if (mem_busy) begin
      state <= MEM_WAIT;
      if (wait_ctr != '1) wait_ctr <= wait_ctr + 8'd1;
      if (wait_hit) timeout_err <= 1'b1;
    end else begin
      wait_ctr <= '0;
      state    <= branch_go ? FLUSH : RUN;
      if (id_ex_bubble) begin
        fwd_a <= '0;
        fwd_b <= '0;
      end else begin
        fwd_a <= fwd_a_next;
        fwd_b <= fwd_b_next;
      end
    end
  end

`ifdef HAZARD_STATS_EN
  logic ev_stall;
  logic ev_flush;

  always_comb begin
    ev_stall = !mem_busy && !branch_go && stall;
    ev_flush = !mem_busy && (branch_go || (!stall && (id_jump || id_jr)));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
      wait_cnt  <= '0;
    end else begin
      if (ev_stall && stall_cnt != '1) stall_cnt <= stall_cnt + CNT_W'(1);
      if (ev_flush && flush_cnt != '1) flush_cnt <= flush_cnt + CNT_W'(1);
      if (mem_busy && wait_cnt  != '1) wait_cnt  <= wait_cnt  + CNT_W'(1);
    end
  end
`else
  logic [CNT_W-1:0] stats_unused;
  assign stats_unused = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: table-driven reference model plus directed
// literal expectations; honours HAZARD_STATS_EN when defined.
module tb_pipeline_hazard_ctrl;

  localparam int unsigned TIMEOUT = 16;

  typedef struct {
    logic [4:0] rs, rt;
    logic       uses_rt, jump, jr;
    logic [4:0] ex_rd;
    logic       ex_rw, ex_mr;
    logic [4:0] mem_rd;
    logic       mem_rw, mem_mr, taken, busy;
  } vin_t;

  logic clk = 1'b0;
  logic reset;
  logic [4:0] id_rs, id_rt, ex_rd, mem_rd;
  logic id_uses_rt, id_jump, id_jr, ex_regwrite, ex_memread;
  logic mem_regwrite, mem_memread, mem_branch_taken, mem_busy;
  logic pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_bubble;
  logic ex_mem_write, ex_mem_bubble, mem_wb_write, timeout_err;
  logic [1:0] fwd_a, fwd_b;
`ifdef HAZARD_STATS_EN
  logic [15:0] stall_cnt, flush_cnt, wait_cnt;
`endif

  int errors = 0;
  int checks = 0;

  // reference model state
  bit       m_squash;
  int       m_wait;
  bit       m_err;
  bit [1:0] m_fa, m_fb;
  int       m_nstall, m_nflush, m_nwait;
  vin_t     v;

  pipeline_hazard_ctrl #(.MEM_TIMEOUT(TIMEOUT), .CNT_W(16)) dut (
    .clk(clk), .reset(reset),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt), .id_jump(id_jump), .id_jr(id_jr),
    .ex_rd(ex_rd), .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
    .mem_rd(mem_rd), .mem_regwrite(mem_regwrite), .mem_memread(mem_memread),
    .mem_branch_taken(mem_branch_taken), .mem_busy(mem_busy),
    .pc_write(pc_write), .if_id_write(if_id_write), .if_id_flush(if_id_flush),
    .id_ex_write(id_ex_write), .id_ex_bubble(id_ex_bubble),
    .ex_mem_write(ex_mem_write), .ex_mem_bubble(ex_mem_bubble), .mem_wb_write(mem_wb_write),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .timeout_err(timeout_err)
`ifdef HAZARD_STATS_EN
    , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .wait_cnt(wait_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic bit hit(input logic [4:0] a, input logic [4:0] b);
    return (a != 0) && (a == b);
  endfunction

  // Cycle classification straight from the priority list
  function automatic int mode(input vin_t x);
    bit lu, jrs;
    lu  = x.ex_mr && (hit(x.ex_rd, x.rs) || (x.uses_rt && hit(x.ex_rd, x.rt)));
    jrs = x.jr && ((x.ex_rw && hit(x.ex_rd, x.rs)) || (x.mem_mr && hit(x.mem_rd, x.rs)));
    if (x.busy) return 0;
    if (x.taken && !m_squash) return 1;
    if (lu || jrs) return 2;
    if (x.jump || x.jr) return 3;
    return 4;
  endfunction

  // {pc, ifid_w, ifid_flush, idex_w, idex_bub, exmem_w, exmem_bub, memwb_w}
  function automatic logic [7:0] pattern(input int m);
    logic [7:0] tbl [5];
    tbl[0] = 8'b0000_0000;
    tbl[1] = 8'b1111_1111;
    tbl[2] = 8'b0001_1101;
    tbl[3] = 8'b1111_0101;
    tbl[4] = 8'b1101_0101;
    return tbl[m];
  endfunction

  function automatic bit [1:0] newest(input logic [4:0] r, input bit en, input vin_t x);
    if (!en || r == 0) return 2'b00;
    if (x.ex_rw && x.ex_rd == r) return 2'b10;
    if (x.mem_rw && x.mem_rd == r) return 2'b01;
    return 2'b00;
  endfunction

  task automatic model_reset();
    m_squash = 0; m_wait = 0; m_err = 0; m_fa = 0; m_fb = 0;
    m_nstall = 0; m_nflush = 0; m_nwait = 0;
  endtask

  task automatic compare();
    chk("ctrl", {pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_bubble,
                 ex_mem_write, ex_mem_bubble, mem_wb_write}, pattern(mode(v)));
    chk("fwd_a", fwd_a, m_fa);
    chk("fwd_b", fwd_b, m_fb);
    chk("timeout_err", timeout_err, m_err);
`ifdef HAZARD_STATS_EN
    chk("stall_cnt", stall_cnt, m_nstall[15:0]);
    chk("flush_cnt", flush_cnt, m_nflush[15:0]);
    chk("wait_cnt", wait_cnt, m_nwait[15:0]);
`endif
  endtask

  task automatic apply(input vin_t x);
    @(negedge clk);
    v = x;
    id_rs = x.rs; id_rt = x.rt; id_uses_rt = x.uses_rt; id_jump = x.jump; id_jr = x.jr;
    ex_rd = x.ex_rd; ex_regwrite = x.ex_rw; ex_memread = x.ex_mr;
    mem_rd = x.mem_rd; mem_regwrite = x.mem_rw; mem_memread = x.mem_mr;
    mem_branch_taken = x.taken; mem_busy = x.busy;
    #1 compare();
  endtask

  task automatic tick();
    int m;
    @(posedge clk);
    m = mode(v);
    if (m == 0) begin
      m_wait = (m_wait < 255) ? m_wait + 1 : 255;
      if (m_wait >= TIMEOUT) m_err = 1;
      m_squash = 0;
      m_nwait++;
    end else begin
      m_wait = 0;
      m_squash = (m == 1);
      if (m == 1 || m == 2) begin
        m_fa = 0; m_fb = 0;
      end else begin
        m_fa = newest(v.rs, 1, v);
        m_fb = newest(v.rt, v.uses_rt, v);
      end
      if (m == 2) m_nstall++;
      if (m == 1 || m == 3) m_nflush++;
    end
    #1;
  endtask

  function automatic vin_t idle();
    vin_t x;
    x.rs = 0; x.rt = 0; x.uses_rt = 0; x.jump = 0; x.jr = 0;
    x.ex_rd = 0; x.ex_rw = 0; x.ex_mr = 0;
    x.mem_rd = 0; x.mem_rw = 0; x.mem_mr = 0; x.taken = 0; x.busy = 0;
    return x;
  endfunction

  initial begin
    vin_t x;
    reset = 1'b1;
    v = idle();
    model_reset();
    apply(idle());
    chk("reset_ctrl", {pc_write, if_id_write, if_id_flush, id_ex_bubble, mem_wb_write}, 5'b11001);
    chk("reset_fwd", {fwd_a, fwd_b, timeout_err}, 5'b00000);
    reset = 1'b0;
    tick();

    // load-use on rs
    x = idle(); x.ex_mr = 1; x.ex_rw = 1; x.ex_rd = 8; x.rs = 8;
    apply(x);
    chk("lu_stall", {pc_write, if_id_write, id_ex_bubble}, 3'b001);
    tick();
    x = idle(); x.mem_rd = 8; x.mem_rw = 1; x.mem_mr = 1; x.rs = 8;
    apply(x);
    chk("lu_release", {pc_write, if_id_write, id_ex_write, id_ex_bubble}, 4'b1110);
    tick();
    chk("lu_fwd_a", fwd_a, 2'b01);
    // load-use on rt, with and without id_uses_rt
    x = idle(); x.ex_mr = 1; x.ex_rw = 1; x.ex_rd = 4; x.rs = 2; x.rt = 4; x.uses_rt = 1;
    apply(x); tick();
    x.uses_rt = 0;
    apply(x);
    chk("lu_rt_ungated", pc_write, 1'b1);
    tick();
    // $0 never stalls
    x = idle(); x.ex_mr = 1; x.ex_rd = 0; x.rs = 0;
    apply(x); tick();

    // forwarding: EX beats MEM
    x = idle(); x.ex_rw = 1; x.ex_rd = 9; x.mem_rw = 1; x.mem_rd = 9;
    x.rs = 9; x.rt = 9; x.uses_rt = 1;
    apply(x); tick();
    chk("fwd_ex_prio", {fwd_a, fwd_b}, 4'b1010);
    x.ex_rd = 0; x.mem_rd = 0;
    apply(x); tick();
    chk("fwd_zero", {fwd_a, fwd_b}, 4'b0000);
    x = idle(); x.mem_rw = 1; x.mem_rd = 6; x.rs = 6; x.rt = 6; x.uses_rt = 1;
    apply(x); tick();
    chk("fwd_mem", {fwd_a, fwd_b}, 4'b0101);

    // taken branch, then a re-assertion in the squashed slot
    x = idle(); x.taken = 1; x.ex_rw = 1; x.ex_rd = 3; x.rs = 3;
    apply(x);
    chk("br_flush", {pc_write, if_id_flush, id_ex_bubble, ex_mem_bubble}, 4'b1111);
    tick();
    chk("br_fwd", fwd_a, 2'b00);
    apply(x);
    chk("br_ignored", {if_id_flush, id_ex_bubble, ex_mem_bubble}, 3'b000);
    tick();
    apply(x);
    chk("br_again", if_id_flush, 1'b1);
    tick();

    // jr $31: EX dependency, then MEM load dependency, then redirect
    x = idle(); x.jr = 1; x.rs = 31; x.ex_rw = 1; x.ex_rd = 31;
    apply(x);
    chk("jr_stall1", {pc_write, if_id_write, id_ex_bubble}, 3'b001);
    tick();
    x = idle(); x.jr = 1; x.rs = 31; x.mem_rd = 31; x.mem_mr = 1; x.mem_rw = 1;
    apply(x);
    chk("jr_stall2", {pc_write, if_id_write, id_ex_bubble}, 3'b001);
    tick();
    x = idle(); x.jr = 1; x.rs = 31;
    apply(x);
    chk("jr_redirect", {pc_write, if_id_flush, id_ex_bubble}, 3'b110);
    tick();
    x = idle(); x.jump = 1;
    apply(x);
    chk("j_redirect", {pc_write, if_id_flush}, 2'b11);
    tick();

    // mem wait timeout
    for (int i = 1; i <= 20; i++) begin
      x = idle(); x.busy = 1; x.taken = (i == 3);
      apply(x);
      chk("wait_freeze", {pc_write, if_id_write, id_ex_write, ex_mem_write, mem_wb_write}, 5'b0);
      tick();
      chk("timeout_err", timeout_err, (i >= 16) ? 1'b1 : 1'b0);
    end
    apply(idle());
    chk("err_sticky", timeout_err, 1'b1);
    tick();

    // busy together with branch: freeze first, flush on release
    x = idle(); x.ex_rw = 1; x.ex_rd = 5; x.rs = 5;
    apply(x); tick();
    x = idle(); x.busy = 1; x.taken = 1;
    for (int i = 0; i < 3; i++) begin
      apply(x);
      chk("busy_br_freeze", {pc_write, if_id_flush, ex_mem_bubble}, 3'b000);
      tick();
    end
    x.busy = 0;
    apply(x);
    chk("busy_br_release", {if_id_flush, id_ex_bubble, ex_mem_bubble}, 3'b111);
    tick();

    // async reset in the middle of a wait
    x = idle(); x.ex_rw = 1; x.ex_rd = 7; x.rs = 7;
    apply(x); tick();
    x = idle(); x.busy = 1;
    for (int i = 0; i < 5; i++) begin apply(x); tick(); end
    #2 reset = 1'b1;
    #1;
    chk("async_reset", {fwd_a, fwd_b, timeout_err}, 5'b00000);
    model_reset();
    @(negedge clk) reset = 1'b0;
    apply(idle()); tick();

    // pseudo-random sweep over a small register set
    for (int i = 0; i < 80; i++) begin
      x.rs = 5'($urandom_range(0, 3)); x.rt = 5'($urandom_range(0, 3));
      x.uses_rt = 1'($urandom_range(0, 1)); x.jump = ($urandom_range(0, 5) == 0);
      x.jr = ($urandom_range(0, 5) == 0);
      x.ex_rd = 5'($urandom_range(0, 3)); x.ex_rw = 1'($urandom_range(0, 1));
      x.ex_mr = ($urandom_range(0, 3) == 0);
      x.mem_rd = 5'($urandom_range(0, 3)); x.mem_rw = 1'($urandom_range(0, 1));
      x.mem_mr = ($urandom_range(0, 3) == 0);
      x.taken = ($urandom_range(0, 4) == 0); x.busy = ($urandom_range(0, 6) == 0);
      apply(x); tick();
    end
    apply(idle());

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, required completion");
    $fatal(1);
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Central hazard/sequencing controller for the 5-stage MIPS pipeline (IF/ID/EX/MEM/WB).
- Generates per-stage write enables, bubble/flush controls and registered EX-stage forwarding selects.
- Resolves load-use hazards, jr register dependencies, jump/branch redirects and data-memory wait states.
- Sits beside the pipeline registers; consumes decoded ID fields and EX/MEM/WB destination info.

Parameters:
- MEM_TIMEOUT, 16, max consecutive mem_busy cycles before timeout_err sets (range 1..255).
- CNT_W, 16, width of the statistics counters (optional feature only).

Ports:
- clk  in  1  pipeline clock
- reset  in  1  asynchronous, active-high reset
- id_rs  in  5  rs field of instruction in ID
- id_rt  in  5  rt field of instruction in ID
- id_uses_rt  in  1  ID instruction reads rt (R-type, beq/bne, sw)
- id_jump  in  1  j/jal decoded in ID
- id_jr  in  1  jr decoded in ID (reads rs in ID)
- ex_rd  in  5  destination register of EX instruction
- ex_regwrite  in  1  EX instruction writes a register
- ex_memread  in  1  EX instruction is a load
- mem_rd  in  5  destination register of MEM instruction
- mem_regwrite  in  1  MEM instruction writes a register
- mem_memread  in  1  MEM instruction is a load
- mem_branch_taken  in  1  branch resolved taken in MEM
- mem_busy  in  1  data memory not ready this cycle
- pc_write  out  1  PC register load enable
- if_id_write  out  1  IF/ID load enable
- if_id_flush  out  1  IF/ID loads NOP
- id_ex_write  out  1  ID/EX load enable
- id_ex_bubble  out  1  ID/EX loads all-zero control
- ex_mem_write  out  1  EX/MEM load enable
- ex_mem_bubble  out  1  EX/MEM loads all-zero control
- mem_wb_write  out  1  MEM/WB load enable
- fwd_a  out  2  EX operand A select: 00 regfile, 01 WB value, 10 MEM value
- fwd_b  out  2  EX operand B select, same encoding
- timeout_err  out  1  sticky mem-wait timeout flag

Behaviour:
- Register $0 never matches any hazard or forward comparison.
- Reset (async): state=RUN, fwd_a=fwd_b=00, timeout_err=0, wait counter=0. Control outputs are combinational from state and inputs; with all inputs low they are all enables=1 and all flush/bubble=0.
- States are RUN, MEM_WAIT and FLUSH. Within a cycle, conditions are evaluated in priority order: MEM_WAIT/mem_busy, then mem_branch_taken, then load-use/jr stall, then jump.
- MEM_WAIT entry and hold: mem_busy=1 in any state enters or holds MEM_WAIT.
  - All five enables are 0; bubbles/flushes are 0; fwd registers hold.
  - Wait counter increments and saturates.
  - Reaching MEM_TIMEOUT sets timeout_err; it clears only on reset.
- MEM_WAIT exit: mem_busy=0 clears the counter and returns to RUN; stall evaluation resumes that same cycle.
- Branch taken, cycle T (RUN, mem_branch_taken=1):
  - pc_write=1, if_id_flush=1, id_ex_bubble=1, ex_mem_bubble=1; other enables 1.
  - Next state FLUSH; fwd registered as 00.
  - FLUSH lasts one cycle with normal RUN decoding, then returns to RUN.
  - A branch asserting in FLUSH is ignored, since it belongs to a squashed slot.
- Load-use stall: ex_memread && ex_rd!=0 && (ex_rd==id_rs || (id_uses_rt && ex_rd==id_rt)).
  - pc_write=0, if_id_write=0, id_ex_bubble=1.
  - Exactly one stall cycle per occurrence.
- jr stall:
  - id_jr with ex_regwrite && ex_rd==id_rs stalls as above.
  - id_jr with mem_memread && mem_rd==id_rs also stalls.
  - A jr may therefore stall 2 cycles.
- Jump/jr redirect (no stall pending): if_id_flush=1, pc_write=1.
- Forwarding: computed from the ID fields and registered on each edge where id_ex_write=1.
  - fwd_a=10 if ex_regwrite && ex_rd==id_rs.
  - Else fwd_a=01 if mem_regwrite && mem_rd==id_rs.
  - Else fwd_a=00.
  - fwd_b uses the same rules with id_rt, gated by id_uses_rt.
  - On any bubble the registered value is 00. The EX-stage match takes precedence over the MEM-stage match (newest value wins).

Optional Feature:
- Macro: HAZARD_STATS_EN.
- Defined: adds outputs stall_cnt[CNT_W-1:0], flush_cnt[CNT_W-1:0], wait_cnt[CNT_W-1:0].
  - stall_cnt counts load-use/jr stall cycles; flush_cnt counts branch+jump flush events; wait_cnt counts MEM_WAIT cycles.
  - All saturate at all-ones and reset to 0.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- lw $8 in EX (ex_memread=1, ex_rd=8), ID reads rs=8 -> one cycle with pc_write=0, if_id_write=0, id_ex_bubble=1; next cycle all enables 1, fwd_a registers 01.
- add $9 in EX (ex_regwrite=1, ex_rd=9), ID rs=9 rt=9 also matched in MEM -> fwd_a=fwd_b=10 after edge; with ex_rd=0 instead -> 00.
- mem_branch_taken=1 -> one cycle if_id_flush=id_ex_bubble=ex_mem_bubble=1; branch re-asserted next cycle (FLUSH) -> ignored.
- id_jr rs=31 with ex_rd=31 ex_regwrite, then mem_rd=31 mem_memread -> 2 stall cycles, then if_id_flush=1.
- mem_busy held 20 cycles with MEM_TIMEOUT=16 -> all enables 0 throughout, timeout_err=1 from cycle 16, stays 1 after busy drops; async reset mid-wait clears all immediately.
- mem_busy and mem_branch_taken asserted together -> freeze only; branch flush occurs on the first cycle busy=0.
